// File: rtl/mips_core_pkg.sv
// Shared core types for the branch predictor: outcome encoding, predictor
// FSM state and the 2-bit saturating counter update rule.
package mips_core_pkg;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef enum logic {
        BP_INIT  = 1'b0,
        BP_READY = 1'b1
    } bp_state_e;

    // Two-bit saturating counter: TAKEN counts up to 11, NOT_TAKEN down to 00.
    function automatic logic [1:0] sat2_update(input logic [1:0] ctr, input BranchOutcome outcome);
        if (outcome == TAKEN) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Pattern history table: 2**IDX_W two-bit counters, one combinational read
// port and one write port. The write port either loads CTR_INIT (init sweep)
// or applies a saturating update to the addressed counter (training).
module bp_counter_table
    import mips_core_pkg::*;
#(
    parameter int          IDX_W    = 10,
    parameter logic [1:0]  CTR_INIT = 2'b01
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic             wr_init,
    input  logic [IDX_W-1:0] wr_idx,
    input  BranchOutcome     wr_outcome
);

    localparam int TABLE_SIZE = 1 << IDX_W;

    logic [1:0] ctr_mem [TABLE_SIZE];

    assign rd_ctr = ctr_mem[rd_idx];

    // Counter storage; contents are meaningless until the init sweep has run.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ctr_mem[wr_idx] <= wr_init ? CTR_INIT : sat2_update(ctr_mem[wr_idx], wr_outcome);
        end
    end

endmodule

// File: rtl/branch_predictor_gshare_ckpt.sv
// Gshare direction predictor with speculative global history, per-prediction
// history checkpoints, mispredict repair and a sequential table-init sweep.
// Optional feature macro: BP_STATS_EN adds saturating branch/mispredict counters.
//
// state    | meaning
// BP_INIT  | sweeping CTR_INIT into every counter; requests/feedback ignored
// BP_READY | predicting, training and tracking history
module branch_predictor_gshare_ckpt
    import mips_core_pkg::*;
#(
    parameter int         ADDR_W   = 32,
    parameter int         IDX_W    = 10,
    parameter int         HIST_W   = 10,
    parameter logic [1:0] CTR_INIT = 2'b01
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              o_ready,
`ifdef BP_STATS_EN
    output logic [31:0]       o_stat_branches,
    output logic [31:0]       o_stat_mispredicts,
`endif
    input  logic              i_req_valid,
    input  logic [ADDR_W-1:0] i_req_pc,
    output BranchOutcome      o_req_prediction,
    output logic [HIST_W-1:0] o_req_ckpt,
    input  logic              i_fb_valid,
    input  logic [ADDR_W-1:0] i_fb_pc,
    input  logic [HIST_W-1:0] i_fb_ckpt,
    input  BranchOutcome      i_fb_prediction,
    input  BranchOutcome      i_fb_outcome
);

    bp_state_e         state_q, state_d;
    logic [IDX_W-1:0]  init_idx_q;
    logic [HIST_W-1:0] ghr_q, ghr_d;

    logic [IDX_W-1:0]  req_idx, fb_idx, wr_idx;
    logic [1:0]        req_ctr;
    logic              wr_en, wr_init;
    logic              fb_act, repair, pred_taken;

    function automatic logic [IDX_W-1:0] bp_hash(input logic [ADDR_W-1:0] pc, input logic [HIST_W-1:0] h);
        return pc[IDX_W+1:2] ^ IDX_W'(h);
    endfunction

    wire unused_pc_bits = ^{i_req_pc[1:0], i_req_pc[ADDR_W-1:IDX_W+2],
                            i_fb_pc[1:0], i_fb_pc[ADDR_W-1:IDX_W+2]};

    assign req_idx    = bp_hash(i_req_pc, ghr_q);
    assign fb_idx     = bp_hash(i_fb_pc, i_fb_ckpt);
    assign pred_taken = o_ready && req_ctr[1];
    assign fb_act     = o_ready && i_fb_valid;
    assign repair     = fb_act && (i_fb_prediction != i_fb_outcome);

    // Write port shared between the init sweep and training.
    assign wr_init = (state_q == BP_INIT);
    assign wr_en   = wr_init || fb_act;
    assign wr_idx  = wr_init ? init_idx_q : fb_idx;

    bp_counter_table #(
        .IDX_W    (IDX_W),
        .CTR_INIT (CTR_INIT)
    ) u_table (
        .clk        (clk),
        .rd_idx     (req_idx),
        .rd_ctr     (req_ctr),
        .wr_en      (wr_en),
        .wr_init    (wr_init),
        .wr_idx     (wr_idx),
        .wr_outcome (i_fb_outcome)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= BP_INIT;
        else        state_q <= state_d;
    end

    // Next state and request-side outputs; the sweep ends after the all-ones index.
    always_comb begin
        state_d          = state_q;
        o_ready          = 1'b0;
        o_req_prediction = NOT_TAKEN;
        o_req_ckpt       = '0;
        case (state_q)
            BP_INIT: begin
                if (init_idx_q == '1) state_d = BP_READY;
            end
            BP_READY: begin
                o_ready          = 1'b1;
                o_req_prediction = req_ctr[1] ? TAKEN : NOT_TAKEN;
                o_req_ckpt       = ghr_q;
            end
            default: state_d = BP_INIT;
        endcase
    end

    // Sweep index; wraps to zero on the final write and then holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  init_idx_q <= '0;
        else if (state_q == BP_INIT) init_idx_q <= init_idx_q + 1'b1;
    end

    // History: repair from the checkpoint beats the speculative shift of a request
    // on the flushed path. The truncating cast drops the oldest bit (or all of
    // them when HIST_W is 1).
    always_comb begin
        ghr_d = ghr_q;
        if (repair) begin
            ghr_d = HIST_W'({i_fb_ckpt, i_fb_outcome == TAKEN});
        end else if (o_ready && i_req_valid) begin
            ghr_d = HIST_W'({ghr_q, pred_taken});
        end
    end

    // Global history register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ghr_q <= '0;
        else        ghr_q <= ghr_d;
    end

`ifdef BP_STATS_EN
    // Saturating feedback and mispredict counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_stat_branches    <= '0;
            o_stat_mispredicts <= '0;
        end else begin
            if (fb_act && o_stat_branches != 32'hFFFF_FFFF) begin
                o_stat_branches <= o_stat_branches + 32'd1;
            end
            if (repair && o_stat_mispredicts != 32'hFFFF_FFFF) begin
                o_stat_mispredicts <= o_stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predictor_gshare_ckpt.sv
// Self-checking bench for branch_predictor_gshare_ckpt (IDX_W=HIST_W=10).
module tb_branch_predictor_gshare_ckpt;
    import mips_core_pkg::*;

    localparam int IDX_W  = 10;
    localparam int HIST_W = 10;
    localparam int TSIZE  = 1 << IDX_W;
    localparam int IMASK  = TSIZE - 1;
    localparam int HMASK  = (1 << HIST_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              o_ready;
    logic              i_req_valid = 1'b0;
    logic [31:0]       i_req_pc = '0;
    BranchOutcome      o_req_prediction;
    logic [HIST_W-1:0] o_req_ckpt;
    logic              i_fb_valid = 1'b0;
    logic [31:0]       i_fb_pc = '0;
    logic [HIST_W-1:0] i_fb_ckpt = '0;
    BranchOutcome      i_fb_prediction = NOT_TAKEN;
    BranchOutcome      i_fb_outcome = NOT_TAKEN;
`ifdef BP_STATS_EN
    logic [31:0]       o_stat_branches;
    logic [31:0]       o_stat_mispredicts;
`endif

    branch_predictor_gshare_ckpt #(
        .ADDR_W   (32),
        .IDX_W    (IDX_W),
        .HIST_W   (HIST_W),
        .CTR_INIT (2'b01)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .o_ready          (o_ready),
`ifdef BP_STATS_EN
        .o_stat_branches    (o_stat_branches),
        .o_stat_mispredicts (o_stat_mispredicts),
`endif
        .i_req_valid      (i_req_valid),
        .i_req_pc         (i_req_pc),
        .o_req_prediction (o_req_prediction),
        .o_req_ckpt       (o_req_ckpt),
        .i_fb_valid       (i_fb_valid),
        .i_fb_pc          (i_fb_pc),
        .i_fb_ckpt        (i_fb_ckpt),
        .i_fb_prediction  (i_fb_prediction),
        .i_fb_outcome     (i_fb_outcome)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: counter values as plain integers, history as an integer.
    int m_ctr [TSIZE];
    int m_ghr;
    int m_br;
    int m_mis;

    logic        obs_pred;
    logic [31:0] obs_ckpt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < TSIZE; i++) m_ctr[i] = 1;
        m_ghr = 0;
        m_br  = 0;
        m_mis = 0;
    endtask

    // Release reset and count cycles until ready, checking INIT behaviour meanwhile.
    task automatic bring_up(input int abort_after);
        int n;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (o_ready !== 1'b1 && n < 2000) begin
            i_req_valid     = 1'b1;
            i_req_pc        = $urandom & 32'hFFFF_FFFC;
            i_fb_valid      = 1'b1;
            i_fb_pc         = $urandom & 32'hFFFF_FFFC;
            i_fb_ckpt       = HIST_W'($urandom);
            i_fb_prediction = NOT_TAKEN;
            i_fb_outcome    = TAKEN;
            #1;
            if (n < 24) begin
                chk("init_pred", 32'(o_req_prediction), 32'(NOT_TAKEN));
                chk("init_ckpt", 32'(o_req_ckpt), 32'd0);
            end
            if (abort_after != 0 && n == abort_after) begin
                rst_n = 1'b0;
                #1;
                chk("midsweep_ready", 32'(o_ready), 32'd0);
                return;
            end
            @(posedge clk);
            #1;
            n++;
            @(negedge clk);
        end
        i_req_valid = 1'b0;
        i_fb_valid  = 1'b0;
        chk("ready_latency", n, TSIZE);
        model_reset();
    endtask

    // One cycle: drive, check outputs against the model, then advance the model.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic fv, input logic [31:0] fpc,
                        input int fck, input logic fp, input logic fo);
        int  ri, fi;
        logic exp_p;
        @(negedge clk);
        i_req_valid     = rv;
        i_req_pc        = rpc;
        i_fb_valid      = fv;
        i_fb_pc         = fpc;
        i_fb_ckpt       = HIST_W'(fck);
        i_fb_prediction = fp ? TAKEN : NOT_TAKEN;
        i_fb_outcome    = fo ? TAKEN : NOT_TAKEN;
        #1;
        ri    = ((rpc >> 2) ^ m_ghr) & IMASK;
        exp_p = (m_ctr[ri] >= 2);
        chk("ready", 32'(o_ready), 32'd1);
        chk("pred", 32'(o_req_prediction), 32'(exp_p));
        chk("ckpt", 32'(o_req_ckpt), m_ghr);
`ifdef BP_STATS_EN
        chk("stat_br", o_stat_branches, m_br);
        chk("stat_mis", o_stat_mispredicts, m_mis);
`endif
        obs_pred = (o_req_prediction == TAKEN);
        obs_ckpt = 32'(o_req_ckpt);
        @(posedge clk);
        if (fv) begin
            fi = ((fpc >> 2) ^ (fck & HMASK)) & IMASK;
            if (fo) m_ctr[fi] = (m_ctr[fi] == 3) ? 3 : m_ctr[fi] + 1;
            else    m_ctr[fi] = (m_ctr[fi] == 0) ? 0 : m_ctr[fi] - 1;
            m_br++;
        end
        if (fv && fp != fo) begin
            m_mis++;
            m_ghr = (((fck & HMASK) << 1) | int'(fo)) & HMASK;
        end else if (rv) begin
            m_ghr = ((m_ghr << 1) | int'(exp_p)) & HMASK;
        end
    endtask

    initial begin
        #12;
        chk("reset_ready", 32'(o_ready), 32'd0);
        chk("reset_ckpt", 32'(o_req_ckpt), 32'd0);
        bring_up(0);

        // Fresh table predicts weakly not-taken.
        step(0, 32'h40, 0, 0, 0, 0, 0);
        chk("fresh_nt", 32'(obs_pred), 32'd0);

`ifdef BP_STATS_EN
        // Three feedbacks, one of them a mispredict.
        step(0, 0, 1, 32'h800, 0, 1, 1);
        step(0, 0, 1, 32'h804, 0, 0, 0);
        step(0, 0, 1, 32'h808, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
`ifdef BP_STATS_EN
        chk("stats_br3", o_stat_branches, 32'd3);
        chk("stats_mis1", o_stat_mispredicts, 32'd1);
`endif
        // Repair above set history to 1; restore it to 0.
        step(0, 0, 1, 32'hC00, 0, 1, 0);
`endif

        // Two TAKEN trainings push the counter to 11 -> predict TAKEN.
        step(0, 0, 1, 32'h40, 0, 1, 1);
        step(0, 0, 1, 32'h40, 0, 1, 1);
        step(0, 32'h40, 0, 0, 0, 0, 0);
        chk("trained_taken", 32'(obs_pred), 32'd1);
        // Third TAKEN saturates; one NOT_TAKEN leaves 10, still TAKEN.
        step(0, 0, 1, 32'h40, 0, 1, 1);
        step(0, 0, 1, 32'h40, 0, 1, 0);
        step(0, 32'h40, 0, 0, 0, 0, 0);
        chk("saturate_taken", 32'(obs_pred), 32'd1);

        // Speculative history: TAKEN then NOT_TAKEN then NOT_TAKEN.
        step(1, 32'h40, 0, 0, 0, 0, 0);
        chk("spec_ckpt0", obs_ckpt, 32'h000);
        step(1, 32'h40, 0, 0, 0, 0, 0);
        chk("spec_ckpt1", obs_ckpt, 32'h001);
        step(1, 32'h40, 0, 0, 0, 0, 0);
        chk("spec_ckpt2", obs_ckpt, 32'h002);

        // Repair to 0x2AA, then repair plus concurrent request -> 0x2AB.
        step(0, 0, 1, 32'h200, 32'h155, 1, 0);
        step(1, 32'h300, 1, 32'h100, 32'h155, 0, 1);
        chk("repair_ghr", obs_ckpt, 32'h2AA);
        step(0, 32'hEF8, 0, 0, 0, 0, 0);
        chk("repair_win", obs_ckpt, 32'h2AB);
        chk("trained_0x115", 32'(obs_pred), 32'd1);

        // Same index read and written: old value now, new value next cycle.
        step(1, 32'hEF8, 1, 32'hEF8, 32'h2AB, 0, 0);
        chk("rw_old", 32'(obs_pred), 32'd1);
        step(0, 32'h108, 0, 0, 0, 0, 0);
        chk("rw_new_ckpt", obs_ckpt, 32'h157);
        chk("rw_new", 32'(obs_pred), 32'd0);

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom), $urandom & 32'hFFFF_FFFC, 1'($urandom), $urandom & 32'hFFFF_FFFC,
                 int'($urandom & 32'(HMASK)), 1'($urandom), 1'($urandom));
        end

        // Reset in READY, reset again mid-sweep, then a full sweep.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_ckpt", 32'(o_req_ckpt), 32'd0);
`ifdef BP_STATS_EN
        chk("rst_stat_br", o_stat_branches, 32'd0);
        chk("rst_stat_mis", o_stat_mispredicts, 32'd0);
`endif
        bring_up(7);
        bring_up(0);
        step(1, $urandom & 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        chk("post_rst_ckpt", obs_ckpt, 32'd0);
        chk("post_rst_nt", 32'(obs_pred), 32'd0);
        for (int k = 0; k < 50; k++) begin
            step(1'($urandom), $urandom & 32'hFFFF_FFFC, 1'($urandom), $urandom & 32'hFFFF_FFFC,
                 int'($urandom & 32'(HMASK)), 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
